// File: rtl/alu_mul_defs.sv
// Shared constants for the shift-add multiplier: FSM encodings, ALU opcode, widths.
package alu_mul_defs;

  localparam int OP_W  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_PSA = 3'b100;
  localparam logic [2:0] OP_PSB = 3'b101;
  localparam logic [2:0] OP_ADD = 3'b110;
  localparam logic [2:0] OP_SUB = 3'b111;

endpackage

// File: rtl/alu_mul_seq_alu32.sv
// 32-bit combinational ALU with carry, negative, zero and signed-overflow flags.
module alu32
  import alu_mul_defs::*;
(
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  input  logic [2:0]      op_i,
  output logic [OP_W-1:0] y_o,
  output logic            c_o,
  output logic            n_o,
  output logic            z_o,
  output logic            v_o
);

  logic [OP_W:0] add_ext;
  logic [OP_W:0] sub_ext;

  assign add_ext = {1'b0, a_i} + {1'b0, b_i};
  assign sub_ext = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    y_o = '0;
    c_o = 1'b0;
    v_o = 1'b0;
    unique case (op_i)
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_NOR: y_o = ~(a_i | b_i);
      OP_PSA: y_o = a_i;
      OP_PSB: y_o = b_i;
      OP_ADD: begin
        y_o = add_ext[OP_W-1:0];
        c_o = add_ext[OP_W];
        v_o = (a_i[OP_W-1] == b_i[OP_W-1]) && (y_o[OP_W-1] != a_i[OP_W-1]);
      end
      OP_SUB: begin
        y_o = sub_ext[OP_W-1:0];
        // carry reads as "no borrow"
        c_o = ~sub_ext[OP_W];
        v_o = (a_i[OP_W-1] != b_i[OP_W-1]) && (y_o[OP_W-1] != a_i[OP_W-1]);
      end
      default: y_o = '0;
    endcase
  end

  assign n_o = y_o[OP_W-1];
  assign z_o = (y_o == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned 32x32->64 sequential multiplier: one shift-add step per EXEC cycle via alu32.
module alu_mul_seq
  import alu_mul_defs::*;
#(
  parameter int N_ITER = 32
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_W-1:0]     multiplicand,
  input  logic [OP_W-1:0]     multiplier,
  output logic                busy,
  output logic                done,
  output logic [2*OP_W-1:0]   result
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

  state_e               state_q, state_d;
  logic [OP_W-1:0]      mcand_q, mcand_d;
  logic [2*OP_W-1:0]    p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*OP_W-1:0]    res_q, res_d;

  logic [OP_W-1:0]      addend;
  logic [OP_W-1:0]      sum;
  logic                 sum_c;
  logic [2*OP_W-1:0]    p_step;

  assign addend = mcand_q & {OP_W{p_q[0]}};

  alu32 u_alu (
    .a_i  (p_q[2*OP_W-1:OP_W]),
    .b_i  (addend),
    .op_i (OP_ADD),
    .y_o  (sum),
    .c_o  (sum_c),
    .n_o  (),
    .z_o  (),
    .v_o  ()
  );

  // carry lands in the top bit so no product bit is ever dropped
  assign p_step = {sum_c, sum, p_q[OP_W-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
          mcand_d = multiplicand;
          p_d     = {{OP_W{1'b0}}, multiplier};
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      EXEC: begin
        p_d = p_step;
        if (cnt_q == LAST) begin
          state_d = DONE;
          res_d   = p_step;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed corner cases plus random operands vs A*B.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int n_chk;
  int n_err;

  alu_mul_seq #(.N_ITER(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Issue one operation and watch 34 cycles after the accepting edge.
  // With hold=1, start stays high and operands change to 9/9 mid-run.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                        input string tag, input bit full);
    int          busy_cnt;
    int          done_cnt;
    int          done_at;
    logic [63:0] exp;
    logic [63:0] res_seen;
    exp      = ref_mul(a, b);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    res_seen = '0;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) start = 1'b0;
      if (hold && k == 5) begin
        multiplicand = 32'd9;
        multiplier   = 32'd9;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at  = k;
        res_seen = result;
      end
      if (k == 34) begin
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_held"}, result, exp);
      end
    end
    chk({tag, "_result"}, res_seen, exp);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (full) begin
      chk({tag, "_latency"}, 64'(done_at), 64'd33);
      chk({tag, "_busy_cnt"}, 64'(busy_cnt), 64'd33);
    end
  endtask

  task automatic wait_done(input logic [63:0] exp, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        chk({tag, "_result"}, result, exp);
      end
    end
    chk({tag, "_done_seen"}, 64'(found), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          spurious;

    n_chk        = 0;
    n_err        = 0;
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    reset = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, "basic", 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "allones", 1'b1);
    chk("allones_const", result, 64'hFFFF_FFFE_0000_0001);
    run_op(32'h1234_5678, 32'd0, 1'b0, "b_zero", 1'b0);
    run_op(32'd0, 32'h89AB_CDEF, 1'b0, "a_zero", 1'b0);
    ra = $urandom;
    run_op(ra, 32'd1, 1'b0, "b_one", 1'b0);
    chk("b_one_const", result, {32'h0, ra});

    // start held through the run; a second op must begin right after DONE
    run_op(32'h0001_0003, 32'h0000_0100, 1'b1, "hold", 1'b1);
    @(negedge clk);
    chk("hold_restart_busy", 64'(busy), 64'd1);
    chk("hold_restart_clr", result, 64'd0);
    start = 1'b0;
    wait_done(64'd81, "hold2");
    @(negedge clk);

    // reset during EXEC aborts without a done pulse
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 32'hDEAD_BEEF;
    multiplier   = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", result, 64'd0);
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    chk("abort_quiet", 64'(spurious), 64'd0);
    run_op(32'd3, 32'd5, 1'b0, "after_abort", 1'b1);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = ra >> $urandom_range(31, 0);
      run_op(ra, rb, 1'b0, "rand", (i % 100) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
